// File: rtl/pipe_skid_reg_if.sv
// ============================================================================
// Module      : pipe_skid_reg_if
// Description : valid/ready handshake bundle carrying a data and control payload.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipe_skid_reg_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  modport master (output valid, output data, output ctrl, input ready);
  modport slave  (input valid, input data, input ctrl, output ready);
endinterface

`default_nettype wire

// File: rtl/pipe_skid_reg.sv
// ============================================================================
// Module      : pipe_skid_reg
// Description : 2-entry skid buffer pipeline stage with hold, flush and a
//               saturating downstream-stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_skid_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  pipe_skid_reg_if.slave   up,
  pipe_skid_reg_if.master  dn,
  input  logic             hold,
  input  logic             flush,
  input  logic             clr_cnt,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int               PAY_W     = DATA_W + CTRL_W;
  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PAY_W-1:0]   r_main;
  logic [PAY_W-1:0]   r_skid;
  logic [PAY_W-1:0]   w_main_nxt;
  logic [PAY_W-1:0]   w_skid_nxt;
  logic [PAY_W-1:0]   w_up_pay;
  logic [CNT_W-1:0]   r_stall_cnt;
  logic               w_in_xfer;
  logic               w_out_xfer;
  logic               w_stall;

  // up.ready must not depend on dn.ready, so the skid slot absorbs the bubble.
  assign up.ready   = !hold && (r_state != TWO);
  assign dn.valid   = (r_state != EMPTY);
  assign w_up_pay   = {up.ctrl, up.data};
  assign w_in_xfer  = up.valid & up.ready;
  assign w_out_xfer = dn.valid & dn.ready & !hold & !flush;
  assign w_stall    = dn.valid & (!dn.ready | hold) & !flush;

  // Bubbles drive zeros so downstream write-enables stay low.
  assign {dn.ctrl, dn.data} = dn.valid ? r_main : '0;
  assign occupancy          = r_state;
  assign stall_cnt          = r_stall_cnt;

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (flush) begin
      w_state_nxt = EMPTY;
      w_main_nxt  = '0;
      w_skid_nxt  = '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_xfer) begin
            w_state_nxt = ONE;
            w_main_nxt  = w_up_pay;
          end
        end
        ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            w_main_nxt = w_up_pay;
          end else if (w_in_xfer) begin
            w_state_nxt = TWO;
            w_skid_nxt  = w_up_pay;
          end else if (w_out_xfer) begin
            w_state_nxt = EMPTY;
          end
        end
        TWO: begin
          if (w_out_xfer) begin
            w_state_nxt = ONE;
            w_main_nxt  = r_skid;
          end
        end
        default: begin
          w_state_nxt = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (clr_cnt) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != c_CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
// ============================================================================
// Module      : tb_pipe_skid_reg
// Description : self-checking bench for pipe_skid_reg against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_skid_reg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hold = 1'b0;
  logic        flush = 1'b0;
  logic        clr_cnt = 1'b0;
  logic [1:0]  occupancy;
  logic [15:0] stall_cnt;
  logic [1:0]  occupancy2;
  logic [1:0]  stall_cnt2;

  int checks = 0;
  int errors = 0;

  logic [35:0] model_q[$];
  int          model_cnt = 0;

  pipe_skid_reg_if #(.DATA_W(32), .CTRL_W(4)) up_if ();
  pipe_skid_reg_if #(.DATA_W(32), .CTRL_W(4)) dn_if ();
  pipe_skid_reg_if #(.DATA_W(32), .CTRL_W(4)) up2_if ();
  pipe_skid_reg_if #(.DATA_W(32), .CTRL_W(4)) dn2_if ();

  pipe_skid_reg #(.DATA_W(32), .CTRL_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .up(up_if.slave), .dn(dn_if.master),
    .hold(hold), .flush(flush), .clr_cnt(clr_cnt),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  pipe_skid_reg #(.DATA_W(32), .CTRL_W(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .up(up2_if.slave), .dn(dn2_if.master),
    .hold(hold), .flush(flush), .clr_cnt(clr_cnt),
    .occupancy(occupancy2), .stall_cnt(stall_cnt2)
  );

  always #5 clk = ~clk;

  logic [55:0] obs;
  assign obs = {up_if.ready, dn_if.valid, dn_if.data, dn_if.ctrl, occupancy, stall_cnt};

  function automatic logic [55:0] exp_vec();
    logic [35:0] head;
    head = (model_q.size() != 0) ? model_q[0] : 36'h0;
    return {(!hold && model_q.size() < 2), (model_q.size() != 0), head[31:0], head[35:32],
            2'(model_q.size()), 16'(model_cnt)};
  endfunction

  // Reference behaviour at a rising edge: a bounded FIFO of depth 2.
  task automatic model_update();
    int n;
    n = model_q.size();
    if (clr_cnt) model_cnt = 0;
    else if (n > 0 && (!dn_if.ready || hold) && !flush && model_cnt < 65535) model_cnt++;
    if (flush) begin
      model_q.delete();
    end else if (!hold) begin
      if (n > 0 && dn_if.ready) void'(model_q.pop_front());
      if (up_if.valid && n < 2) model_q.push_back({up_if.ctrl, up_if.data});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic drive(input bit uv, input logic [31:0] d, input logic [3:0] c,
                       input bit dr, input bit h, input bit f, input bit cc);
    up_if.valid = uv;
    up_if.data  = d;
    up_if.ctrl  = c;
    dn_if.ready = dr;
    hold        = h;
    flush       = f;
    clr_cnt     = cc;
  endtask

  task automatic test_reset();
    drive(0, 32'h0, 4'h0, 0, 0, 0, 0);
    #1;
    checks++;
    if (obs !== {1'b1, 1'b0, 32'h0, 4'h0, 2'd0, 16'd0}) begin
      errors++; $display("FAIL reset_state got %h exp %h", obs, {1'b1, 1'b0, 32'h0, 4'h0, 2'd0, 16'd0});
    end
    hold = 1'b1;
    #1;
    checks++;
    if (up_if.ready !== 1'b0 || dn_if.valid !== 1'b0) begin
      errors++; $display("FAIL reset_hold_ready got rdy=%b vld=%b exp rdy=0 vld=0", up_if.ready, dn_if.valid);
    end
    hold = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_streaming();
    for (int i = 1; i <= 4; i++) begin
      drive(1, 32'(i), 4'(i), 1, 0, 0, 0);
      #1;
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL stream_model cyc %0d got %h exp %h", i, obs, exp_vec());
      end
      tick();
      checks++;
      if (dn_if.data !== 32'(i) || occupancy !== 2'd1 || stall_cnt !== 16'd0) begin
        errors++; $display("FAIL stream_out cyc %0d got data=%0d occ=%0d cnt=%0d exp data=%0d occ=1 cnt=0",
                           i, dn_if.data, occupancy, stall_cnt, i);
      end
    end
    drive(0, 32'h0, 4'h0, 1, 0, 0, 0);
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] vals [3];
    vals[0] = 32'hA; vals[1] = 32'hB; vals[2] = 32'hC;
    for (int i = 0; i < 3; i++) begin
      drive(1, vals[i], 4'h1, 0, 0, 0, (i == 0));
      #1;
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL bp_fill cyc %0d got %h exp %h", i, obs, exp_vec());
      end
      tick();
    end
    checks++;
    if (occupancy !== 2'd2 || up_if.ready !== 1'b0 || stall_cnt !== 16'd2 || dn_if.data !== 32'hA) begin
      errors++; $display("FAIL bp_full got occ=%0d rdy=%b cnt=%0d data=%h exp occ=2 rdy=0 cnt=2 data=a",
                         occupancy, up_if.ready, stall_cnt, dn_if.data);
    end
    for (int i = 0; i < 4; i++) begin
      drive((i < 2), 32'hC, 4'h1, 1, 0, 0, 0);
      #1;
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL bp_drain cyc %0d got %h exp %h", i, obs, exp_vec());
      end
      if (i < 3) begin
        checks++;
        if (dn_if.data !== vals[i]) begin
          errors++; $display("FAIL bp_order cyc %0d got %h exp %h", i, dn_if.data, vals[i]);
        end
      end
      tick();
    end
  endtask

  task automatic test_hold();
    drive(1, 32'h55, 4'hF, 1, 0, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h77, 4'h3, 1, 1, 0, 0);
      #1;
      checks++;
      if (obs !== exp_vec() || dn_if.data !== 32'h55 || dn_if.ctrl !== 4'hF || up_if.ready !== 1'b0) begin
        errors++; $display("FAIL hold cyc %0d got %h exp %h", i, obs, exp_vec());
      end
      tick();
    end
    drive(0, 32'h0, 4'h0, 1, 0, 0, 0);
    #1;
    checks++;
    if (obs !== exp_vec()) begin
      errors++; $display("FAIL hold_release got %h exp %h", obs, exp_vec());
    end
    tick();
  endtask

  task automatic test_flush();
    drive(1, 32'h11, 4'h2, 0, 0, 0, 0);
    tick();
    drive(1, 32'h22, 4'h4, 0, 0, 0, 0);
    tick();
    drive(1, 32'h33, 4'h8, 1, 1, 1, 0);
    #1;
    checks++;
    if (obs !== exp_vec()) begin
      errors++; $display("FAIL flush_pre got %h exp %h", obs, exp_vec());
    end
    tick();
    drive(0, 32'h0, 4'h0, 0, 0, 0, 0);
    #1;
    checks++;
    if (occupancy !== 2'd0 || dn_if.valid !== 1'b0 || dn_if.data !== 32'h0 || dn_if.ctrl !== 4'h0
        || obs !== exp_vec()) begin
      errors++; $display("FAIL flush_post got %h exp %h", obs, exp_vec());
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, $urandom, 4'($urandom), ($urandom % 3) != 0,
            ($urandom % 6) == 0, ($urandom % 25) == 0, ($urandom % 30) == 0);
      #1;
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL random cyc %0d got %h exp %h", i, obs, exp_vec());
      end
      tick();
    end
    drive(0, 32'h0, 4'h0, 1, 0, 1, 1);
    tick();
  endtask

  task automatic test_counter_sat();
    int exp_cnt [5];
    exp_cnt[0] = 1; exp_cnt[1] = 2; exp_cnt[2] = 3; exp_cnt[3] = 3; exp_cnt[4] = 3;
    drive(0, 32'h0, 4'h0, 0, 0, 0, 0);
    up2_if.valid = 1'b1; up2_if.data = 32'h9; up2_if.ctrl = 4'h1; dn2_if.ready = 1'b0;
    tick();
    up2_if.valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (stall_cnt2 !== 2'(exp_cnt[i])) begin
        errors++; $display("FAIL cnt_sat cyc %0d got %0d exp %0d", i, stall_cnt2, exp_cnt[i]);
      end
    end
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    checks++;
    if (stall_cnt2 !== 2'd0 || occupancy2 !== 2'd1) begin
      errors++; $display("FAIL cnt_clr got cnt=%0d occ=%0d exp cnt=0 occ=1", stall_cnt2, occupancy2);
    end
  endtask

  task automatic test_async_reset();
    drive(1, 32'hA1, 4'h1, 0, 0, 0, 0);
    tick();
    drive(1, 32'hB2, 4'h2, 0, 0, 0, 0);
    tick();
    drive(0, 32'h0, 4'h0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    model_q.delete();
    model_cnt = 0;
    #1;
    checks++;
    if (obs !== exp_vec() || occupancy2 !== 2'd0 || dn2_if.valid !== 1'b0) begin
      errors++; $display("FAIL async_reset got %h exp %h", obs, exp_vec());
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 32'hABC, 4'h5, 0, 0, 0, 0);
    tick();
    drive(0, 32'h0, 4'h0, 0, 0, 0, 0);
    #1;
    checks++;
    if (dn_if.valid !== 1'b1 || dn_if.data !== 32'hABC || dn_if.ctrl !== 4'h5 || obs !== exp_vec()) begin
      errors++; $display("FAIL post_reset_push got %h exp %h", obs, exp_vec());
    end
  endtask

  initial begin
    up2_if.valid = 1'b0; up2_if.data = '0; up2_if.ctrl = '0; dn2_if.ready = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_hold();
    test_flush();
    test_random();
    test_counter_sat();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter: DATA_W, 32, width of the datapath payload (e.g. ALU result, memory data, PC+4 concatenated).
REQ-002 Parameter: CTRL_W, 4, width of the control payload (e.g. reg_wr, wb_sel, call, spare).
REQ-003 Parameter: CNT_W, 16, width of the stall-cycle counter.
REQ-004 Port: clk  input  1  clock; all state changes on rising edge.
REQ-005 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port: up_valid  input  1  upstream stage presents a valid entry.
REQ-007 Port: up_ready  output  1  block accepts an entry this cycle.
REQ-008 Port: up_data  input  DATA_W  upstream datapath payload.
REQ-009 Port: up_ctrl  input  CTRL_W  upstream control payload.
REQ-010 Port: dn_valid  output  1  block presents a valid entry downstream.
REQ-011 Port: dn_ready  input  1  downstream accepts the entry this cycle.
REQ-012 Port: dn_data  output  DATA_W  downstream datapath payload.
REQ-013 Port: dn_ctrl  output  CTRL_W  downstream control payload.
REQ-014 Port: hold  input  1  hazard-unit stall; freezes the stage.
REQ-015 Port: flush  input  1  squash all held entries.
REQ-016 Port: clr_cnt  input  1  synchronous clear of stall counter.
REQ-017 Port: occupancy  output  2  held entries: 0, 1 or 2.
REQ-018 Port: stall_cnt  output  CNT_W  saturating count of downstream-stall cycles.

Function
REQ-019 The block SHALL be a 2-entry skid buffer: main register (drives outputs) plus one skid register, with state EMPTY (0 entries), ONE (main full), TWO (main and skid full).
REQ-020 Definitions: in_xfer = up_valid & up_ready; out_xfer = dn_valid & dn_ready & !hold & !flush.
REQ-021 up_ready SHALL equal !hold & (state != TWO), combinational from registered state and hold only (no path from dn_ready).
REQ-022 dn_valid SHALL be 1 exactly when state != EMPTY and hold-independent.
REQ-023 dn_data and dn_ctrl SHALL drive main-register contents when dn_valid=1 and SHALL drive all zeros when dn_valid=0, so a bubble never asserts write-enables.
REQ-024 EMPTY: in_xfer -> ONE, main <= up payload; otherwise stay.
REQ-025 ONE: in_xfer & out_xfer -> ONE, main <= up payload; in_xfer & !out_xfer -> TWO, skid <= up payload; !in_xfer & out_xfer -> EMPTY; neither -> stay.
REQ-026 TWO: out_xfer -> ONE, main <= skid; otherwise stay; no in_xfer possible.
REQ-027 Ordering SHALL be strict FIFO: entries leave in acceptance order, none dropped or duplicated absent flush.
REQ-028 hold=1 (flush=0): state, main, skid unchanged; up_ready=0; no transfer either side.
REQ-029 flush=1: next state EMPTY, main and skid cleared to zero, regardless of hold, up_valid, dn_ready; any up_valid presented in that cycle is discarded (flush beats hold, hold beats transfer).
REQ-030 Latency: an entry accepted into EMPTY SHALL appear on dn_valid/dn_data on the next cycle; full throughput of one entry per cycle SHALL be sustained when dn_ready=1 and hold=0.
REQ-031 occupancy SHALL be 0/1/2 for EMPTY/ONE/TWO, registered.
REQ-032 stall_cnt SHALL increment by 1 each cycle with dn_valid=1 & (dn_ready=0 | hold=1) & flush=0, saturating at 2^CNT_W-1 (no wrap).
REQ-033 clr_cnt=1 SHALL load stall_cnt with 0 next cycle, taking priority over a same-cycle increment; flush SHALL NOT affect stall_cnt.

Reset
REQ-034 rst_n=0 SHALL immediately force state EMPTY, main, skid and stall_cnt to 0; thus dn_valid=0, dn_data=0, dn_ctrl=0, occupancy=0, up_ready=!hold.
REQ-035 Reset asserted mid-operation SHALL discard all held entries; first accept after deassertion follows REQ-024.

Verification
REQ-036 Streaming: dn_ready=1, up_valid=1 with data 1,2,3,4 on consecutive cycles -> dn_data 1,2,3,4 on next four cycles, occupancy stays 1, stall_cnt=0.
REQ-037 Backpressure: dn_ready=0, push A then B -> occupancy 2, up_ready=0, C not accepted; dn_ready=1 -> A, B, then C after re-accept; stall_cnt=2 when released at second blocked cycle.
REQ-038 Hold: occupancy 1 holding 0x55 with ctrl 0xF, hold=1 for 3 cycles with dn_ready=1 -> dn_data stays 0x55, up_ready=0, stall_cnt +3.
REQ-039 Flush priority: occupancy 2, flush=1 with hold=1 and up_valid=1 -> next cycle occupancy 0, dn_valid=0, dn_data=0, dn_ctrl=0, stall_cnt unchanged.
REQ-040 Counter: CNT_W=2, dn_ready=0 with valid entry for 5 cycles -> stall_cnt 1,2,3,3,3; clr_cnt pulse during blocked cycle -> 0 next cycle.
REQ-041 Async reset: assert rst_n=0 between clock edges while occupancy 2 -> outputs zero before next edge; after release, single push appears one cycle later.
